// File: rtl/regfile_mport.sv
// regfile_mport: NUM_REGS x DATA_W register file, one write port, two registered read ports
module regfile_mport #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter bit ZERO_REG = 1'b0,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    clr,
    input  logic                    rd_en_a,
    input  logic [ADDR_W-1:0]       rd_addr_a,
    output logic [DATA_W-1:0]       rd_data_a,
    output logic                    rd_valid_a,
    input  logic                    rd_en_b,
    input  logic [ADDR_W-1:0]       rd_addr_b,
    output logic [DATA_W-1:0]       rd_data_b,
    output logic                    rd_valid_b,
    output logic [(2**ADDR_W)-1:0]  wr_sel
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [DATA_W-1:0] rd_data_a_q, rd_data_a_d, rd_data_b_q, rd_data_b_d;
    logic              rd_valid_a_q, rd_valid_a_d, rd_valid_b_q, rd_valid_b_d;
    logic              clr_go;

    assign clr_go = en & clr;
    assign wr_sel = (en & wr_en & ~clr) ? NUM_REGS'(1) << wr_addr : '0;

    // value a read launched this cycle captures: hardwired zero, then same-cycle clear/write, then storage
    function automatic logic [DATA_W-1:0] read_val(input logic [ADDR_W-1:0] addr);
        if (ZERO_REG && addr == '0) return '0;
        if (BYPASS && clr_go) return '0;
        if (BYPASS && wr_sel[addr]) return wr_data;
        return regs_q[addr];
    endfunction

    // next storage contents: clear wins over write, register 0 ignores writes when hardwired
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++)
            regs_d[i] = clr_go ? '0 : (wr_sel[i] && !(ZERO_REG && i == 0)) ? wr_data : regs_q[i];
    end

    // read launch per port; data holds when no read is launched
    always_comb begin
        rd_valid_a_d = en & rd_en_a;
        rd_valid_b_d = en & rd_en_b;
        rd_data_a_d  = rd_valid_a_d ? read_val(rd_addr_a) : rd_data_a_q;
        rd_data_b_d  = rd_valid_b_d ? read_val(rd_addr_b) : rd_data_b_q;
    end

    // state registers with asynchronous reset, which also aborts any pending read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            rd_data_a_q  <= '0;
            rd_data_b_q  <= '0;
            rd_valid_a_q <= 1'b0;
            rd_valid_b_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
            rd_data_a_q  <= rd_data_a_d;
            rd_data_b_q  <= rd_data_b_d;
            rd_valid_a_q <= rd_valid_a_d;
            rd_valid_b_q <= rd_valid_b_d;
        end
    end

    assign rd_data_a  = rd_data_a_q;
    assign rd_data_b  = rd_data_b_q;
    assign rd_valid_a = rd_valid_a_q;
    assign rd_valid_b = rd_valid_b_q;
endmodule

// File: tb/tb_regfile_mport.sv
// tb_regfile_mport: scoreboard bench driving a default instance and a ZERO_REG=1/BYPASS=0 instance
module tb_regfile_mport;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0, wr_en = 1'b0, clr = 1'b0, rd_en_a = 1'b0, rd_en_b = 1'b0;
    logic [2:0] wr_addr = '0, rd_addr_a = '0, rd_addr_b = '0;
    logic [7:0] wr_data = '0;
    logic [7:0] wr_sel0, wr_sel1;
    logic [7:0] rdd [4];
    logic       rdv [4];
    logic [7:0] expq [4][$];
    logic [7:0] held [4];
    logic [7:0] mem [2][8];
    logic [7:0] mon_e;
    int         checks = 0, errors = 0;
    bit         mon_on = 1'b0;

    regfile_mport dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr(clr), .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rdd[0]), .rd_valid_a(rdv[0]),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rdd[1]), .rd_valid_b(rdv[1]), .wr_sel(wr_sel0)
    );

    regfile_mport #(.ZERO_REG(1'b1), .BYPASS(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr(clr), .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rdd[2]), .rd_valid_a(rdv[2]),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rdd[3]), .rd_valid_b(rdv[3]), .wr_sel(wr_sel1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference read for instance d (0: bypass, no zero reg; 1: zero reg, no bypass)
    function automatic logic [7:0] model_rd(input int d, input logic [2:0] a);
        if (d == 1 && a == 3'd0) return 8'h00;
        if (d == 0 && en && clr) return 8'h00;
        if (d == 0 && en && wr_en && a == wr_addr) return wr_data;
        return mem[d][a];
    endfunction

    task automatic cycle(input bit e, input bit we, input logic [2:0] wa, input logic [7:0] wd,
                         input bit c, input bit ra, input logic [2:0] aa, input bit rb, input logic [2:0] ab);
        logic [7:0] exp_sel;
        @(posedge clk);
        #1;
        en = e; wr_en = we; wr_addr = wa; wr_data = wd; clr = c;
        rd_en_a = ra; rd_addr_a = aa; rd_en_b = rb; rd_addr_b = ab;
        #1;
        exp_sel = (e && we && !c) ? 8'(1) << wa : 8'h00;
        chk("wr_sel_dut0", wr_sel0, exp_sel);
        chk("wr_sel_dut1", wr_sel1, exp_sel);
        for (int d = 0; d < 2; d++) begin
            if (e && ra) expq[2*d].push_back(model_rd(d, aa));
            if (e && rb) expq[2*d+1].push_back(model_rd(d, ab));
            if (e && c) for (int i = 0; i < 8; i++) mem[d][i] = 8'h00;
            else if (e && we && !(d == 1 && wa == 3'd0)) mem[d][wa] = wd;
        end
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
    endtask

    // reset, optionally while a read of addr 6 on port A is about to launch
    task automatic do_reset(input bit mid);
        @(posedge clk);
        #1;
        if (mid) begin
            en = 1'b1; rd_en_a = 1'b1; rd_addr_a = 3'd6;
            #1;
        end
        rst_n = 1'b0;
        #1;
        en = 1'b0; wr_en = 1'b0; clr = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0;
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("reset_data_p%0d", p), rdd[p], 8'h00);
            chk($sformatf("reset_valid_p%0d", p), rdv[p], 1'b0);
            expq[p].delete();
            held[p] = 8'h00;
        end
        for (int d = 0; d < 2; d++) for (int i = 0; i < 8; i++) mem[d][i] = 8'h00;
        mon_on = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // monitor: every strobe pops an expectation; without a strobe, data must hold
    always @(negedge clk) begin
        if (mon_on) begin
            for (int p = 0; p < 4; p++) begin
                if (rdv[p]) begin
                    if (expq[p].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL strobe_p%0d: got valid=1 expected valid=0", p);
                    end else begin
                        mon_e = expq[p].pop_front();
                        chk($sformatf("rd_data_p%0d", p), rdd[p], mon_e);
                        held[p] = mon_e;
                    end
                end else begin
                    chk($sformatf("hold_p%0d", p), rdd[p], held[p]);
                end
            end
        end
    end

    initial begin
        do_reset(1'b0);
        cycle(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd3, 1'b1, 3'd7);
        idle();
        cycle(1'b1, 1'b1, 3'd2, 8'h5A, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
        chk("decode_addr2", wr_sel0, 8'b0000_0100);
        cycle(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd2, 1'b0, 3'd0);
        cycle(1'b0, 1'b1, 3'd2, 8'h99, 1'b0, 1'b1, 3'd2, 1'b0, 3'd0);
        chk("decode_en0", wr_sel0, 8'h00);
        cycle(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd2, 1'b1, 3'd2);
        cycle(1'b1, 1'b1, 3'd5, 8'h11, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
        cycle(1'b1, 1'b1, 3'd5, 8'hC3, 1'b0, 1'b1, 3'd5, 1'b0, 3'd0);
        cycle(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd5, 1'b0, 3'd0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 3'(i), 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
        cycle(1'b1, 1'b1, 3'd4, 8'h77, 1'b1, 1'b1, 3'd4, 1'b1, 3'd1);
        chk("clr_priority", wr_sel0, 8'h00);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'(i), 1'b1, 3'(7 - i));
        cycle(1'b1, 1'b1, 3'd0, 8'hAA, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
        cycle(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd0, 1'b1, 3'd0);
        cycle(1'b1, 1'b1, 3'd7, 8'h80, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
        cycle(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd7, 1'b1, 3'd7);
        cycle(1'b1, 1'b1, 3'd6, 8'h3C, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
        do_reset(1'b1);
        repeat (3) idle();
        cycle(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'd6, 1'b0, 3'd0);
        repeat (400) begin
            cycle($urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
                  8'($urandom), $urandom_range(0, 19) == 0,
                  $urandom_range(0, 4) < 3, 3'($urandom_range(0, 7)),
                  $urandom_range(0, 4) < 3, 3'($urandom_range(0, 7)));
        end
        repeat (3) idle();
        for (int p = 0; p < 4; p++) chk($sformatf("drain_p%0d", p), expq[p].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
